// File: rtl/mem_bus_arbiter_pkg.sv
// Shared types and defaults for the I/D memory bus arbiter.
// The hold-register struct is sized for the widest supported bus; narrower instances use the low bits.
package mem_bus_arbiter_pkg;

    localparam int ARB_STARVE_LIMIT_DEFAULT = 4;
    localparam int ARB_ADDR_W               = 64;
    localparam int ARB_DATA_W               = 64;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GNT_I = 2'd1,
        GNT_D = 2'd2
    } arb_state_t;

    typedef struct packed {
        logic [ARB_ADDR_W-1:0]   addr;
        logic [2:0]              size;
        logic [ARB_DATA_W/8-1:0] strobe;
        logic [ARB_DATA_W-1:0]   wdata;
    } arb_req_t;

endpackage

// File: rtl/mem_bus_arbiter.sv
// Single-beat bus arbiter between instruction fetch (I) and memory-stage data (D).
// D has priority; a starvation counter forces an I grant after STARVE_LIMIT back-to-back D wins.
//
//   state | meaning
//   IDLE  | no transaction in flight, arbitrate requests this cycle
//   GNT_I | I transaction driven downstream from hold registers until m_data_ok
//   GNT_D | D transaction driven downstream from hold registers until m_data_ok
module mem_bus_arbiter
    import mem_bus_arbiter_pkg::*;
#(
    parameter int ADDR_W       = 64,
    parameter int DATA_W       = 64,
    parameter int STARVE_LIMIT = ARB_STARVE_LIMIT_DEFAULT,
    parameter int CNT_W        = 32
) (
    input  logic                clk,
    input  logic                rst,

    input  logic                i_valid,
    input  logic [ADDR_W-1:0]   i_addr,
    input  logic [2:0]          i_size,
    output logic                i_addr_ok,
    output logic                i_data_ok,
    output logic [DATA_W-1:0]   i_rdata,

    input  logic                d_valid,
    input  logic [ADDR_W-1:0]   d_addr,
    input  logic [2:0]          d_size,
    input  logic [DATA_W/8-1:0] d_strobe,
    input  logic [DATA_W-1:0]   d_wdata,
    output logic                d_addr_ok,
    output logic                d_data_ok,
    output logic [DATA_W-1:0]   d_rdata,

    output logic                m_valid,
    output logic [ADDR_W-1:0]   m_addr,
    output logic [2:0]          m_size,
    output logic [DATA_W/8-1:0] m_strobe,
    output logic [DATA_W-1:0]   m_wdata,
    input  logic                m_addr_ok,
    input  logic                m_data_ok,
    input  logic [DATA_W-1:0]   m_rdata,

    output logic [CNT_W-1:0]    gnt_i_cnt,
    output logic [CNT_W-1:0]    gnt_d_cnt
);

    localparam int               SW         = $clog2(STARVE_LIMIT + 1);
    localparam logic [SW-1:0]    STARVE_MAX = SW'(STARVE_LIMIT);

    arb_state_t     state, state_nxt;
    arb_req_t       hold, req_win;
    logic [SW-1:0]  starve_cnt;
    logic           gnt_i, gnt_d;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            hold       <= '0;
            starve_cnt <= '0;
            gnt_i_cnt  <= '0;
            gnt_d_cnt  <= '0;
        end else begin
            state <= state_nxt;
            if (gnt_i || gnt_d)
                hold <= req_win;
            if (gnt_i)
                starve_cnt <= '0;
            else if (gnt_d && i_valid && starve_cnt != STARVE_MAX)
                starve_cnt <= starve_cnt + SW'(1);
            if (gnt_i && gnt_i_cnt != '1)
                gnt_i_cnt <= gnt_i_cnt + CNT_W'(1);
            if (gnt_d && gnt_d_cnt != '1)
                gnt_d_cnt <= gnt_d_cnt + CNT_W'(1);
        end
    end

    always_comb begin
        state_nxt = state;
        gnt_i     = 1'b0;
        gnt_d     = 1'b0;
        req_win   = '0;
        i_addr_ok = 1'b0;
        i_data_ok = 1'b0;
        i_rdata   = '0;
        d_addr_ok = 1'b0;
        d_data_ok = 1'b0;
        d_rdata   = '0;
        m_valid   = 1'b0;

        case (state)
            IDLE: begin
                // I wins over a pending D only once D has starved it for STARVE_LIMIT grants
                if (d_valid && !(i_valid && starve_cnt == STARVE_MAX)) begin
                    gnt_d                          = 1'b1;
                    state_nxt                      = GNT_D;
                    req_win.addr[ADDR_W-1:0]       = d_addr;
                    req_win.size                   = d_size;
                    req_win.strobe[DATA_W/8-1:0]   = d_strobe;
                    req_win.wdata[DATA_W-1:0]      = d_wdata;
                end else if (i_valid) begin
                    gnt_i                          = 1'b1;
                    state_nxt                      = GNT_I;
                    req_win.addr[ADDR_W-1:0]       = i_addr;
                    req_win.size                   = i_size;
                end
            end
            GNT_I: begin
                m_valid   = 1'b1;
                i_addr_ok = m_addr_ok;
                i_data_ok = m_data_ok;
                i_rdata   = m_rdata;
                if (m_data_ok)
                    state_nxt = IDLE;
            end
            GNT_D: begin
                m_valid   = 1'b1;
                d_addr_ok = m_addr_ok;
                d_data_ok = m_data_ok;
                d_rdata   = m_rdata;
                if (m_data_ok)
                    state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign m_addr   = hold.addr[ADDR_W-1:0];
    assign m_size   = hold.size;
    assign m_strobe = hold.strobe[DATA_W/8-1:0];
    assign m_wdata  = hold.wdata[DATA_W-1:0];

endmodule
